// File: rtl/ddr_tx_sequencer.sv
// ---------------------------------------------------------------------------
// ddr_tx_sequencer
//
// Frame-level controller for the HDR-DDR tx serializer. Holds the serializer
// enabled for a whole frame and steps its 4-bit mode code through the frame
// fields: command word, N data words, CRC word, then the restart or exit
// pattern. A field advances on each serializer mode-done pulse. Every data
// byte sent pops the register file once. Each field has a watchdog.
//
// Ports:
//   i_sys_clk       system clock
//   i_sys_rst       asynchronous active-high reset
//   i_start         one-cycle frame request, sampled only in IDLE
//   i_rnw           1 = read frame (command word only), 0 = write frame
//   i_word_count    number of 2-byte data words for a write
//   i_end_restart   1 = end with restart pattern, 0 = exit pattern
//   i_abort         synchronous abort request
//   i_tx_mode_done  serializer field-complete pulse
//   o_tx_en         serializer enable
//   o_tx_mode       serializer mode code
//   o_regf_rd_en    one-cycle pulse advancing the register-file read pointer
//   o_busy          frame in progress
//   o_done          one-cycle pulse, frame finished normally
//   o_err           one-cycle pulse, timeout / abort / illegal request
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for i_start
// CMD_PRE   | command preamble
// CMD_RNW   | read/write indicator bits
// CMD_ZEROS | command zero padding
// CMD_ADDR  | target address
// CMD_PAR   | command parity; a read frame ends here
// DAT_PRE1  | data preamble, first half
// DAT_PRE0  | data preamble, second half
// DAT_B1    | first data byte
// DAT_B2    | second data byte
// DAT_PAR   | data word parity, loops while words remain
// CRC_PRE   | CRC preamble
// CRC_TOK   | CRC token
// CRC_VAL   | CRC value
// END_PAT   | restart or exit pattern
// FINISH    | one-cycle normal completion
// ---------------------------------------------------------------------------
module ddr_tx_sequencer #(
    parameter int P_TIMEOUT = 255,
    parameter int P_CNT_W   = 8
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    input  logic               i_start,
    input  logic               i_rnw,
    input  logic [P_CNT_W-1:0] i_word_count,
    input  logic               i_end_restart,
    input  logic               i_abort,
    input  logic               i_tx_mode_done,
    output logic               o_tx_en,
    output logic [3:0]         o_tx_mode,
    output logic               o_regf_rd_en,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int              WD_W    = $clog2(P_TIMEOUT + 1);
    // Watchdog fires at the edge that would bring the count to P_TIMEOUT.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(P_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, CMD_PRE, CMD_RNW, CMD_ZEROS, CMD_ADDR, CMD_PAR,
        DAT_PRE1, DAT_PRE0, DAT_B1, DAT_B2, DAT_PAR,
        CRC_PRE, CRC_TOK, CRC_VAL, END_PAT, FINISH
    } state_t;

    state_t             state, state_nxt;
    logic               rnw, rnw_nxt;
    logic               restart, restart_nxt;
    logic [P_CNT_W-1:0] words, words_nxt;
    logic [WD_W-1:0]    wdog, wdog_nxt;
    logic               tx_en_nxt, rd_en_nxt, busy_nxt, done_nxt, err_nxt;
    logic [3:0]         mode_nxt;
    logic               in_field, fault, field_nxt;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state        <= IDLE;
            rnw          <= 1'b0;
            restart      <= 1'b0;
            words        <= '0;
            wdog         <= '0;
            o_tx_en      <= 1'b0;
            o_tx_mode    <= 4'b0000;
            o_regf_rd_en <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_nxt;
            rnw          <= rnw_nxt;
            restart      <= restart_nxt;
            words        <= words_nxt;
            wdog         <= wdog_nxt;
            o_tx_en      <= tx_en_nxt;
            o_tx_mode    <= mode_nxt;
            o_regf_rd_en <= rd_en_nxt;
            o_busy       <= busy_nxt;
            o_done       <= done_nxt;
            o_err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rnw_nxt     = rnw;
        restart_nxt = restart;
        words_nxt   = words;
        rd_en_nxt   = 1'b0;
        err_nxt     = 1'b0;

        in_field = (state != IDLE) && (state != FINISH);
        // Abort and timeout take priority over a coincident mode-done.
        fault    = in_field && (i_abort || (wdog == WD_LAST));

        if (fault) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rnw_nxt     = i_rnw;
                        restart_nxt = i_end_restart;
                        words_nxt   = i_word_count;
                        if (!i_rnw && (i_word_count == '0)) begin
                            err_nxt = 1'b1;
                        end else begin
                            state_nxt = CMD_PRE;
                        end
                    end
                end
                CMD_PRE:   if (i_tx_mode_done) state_nxt = CMD_RNW;
                CMD_RNW:   if (i_tx_mode_done) state_nxt = CMD_ZEROS;
                CMD_ZEROS: if (i_tx_mode_done) state_nxt = CMD_ADDR;
                CMD_ADDR:  if (i_tx_mode_done) state_nxt = CMD_PAR;
                CMD_PAR:   if (i_tx_mode_done) state_nxt = rnw ? FINISH : DAT_PRE1;
                DAT_PRE1:  if (i_tx_mode_done) state_nxt = DAT_PRE0;
                DAT_PRE0:  if (i_tx_mode_done) state_nxt = DAT_B1;
                DAT_B1: begin
                    if (i_tx_mode_done) begin
                        state_nxt = DAT_B2;
                        rd_en_nxt = 1'b1;
                    end
                end
                DAT_B2: begin
                    if (i_tx_mode_done) begin
                        state_nxt = DAT_PAR;
                        rd_en_nxt = 1'b1;
                    end
                end
                DAT_PAR: begin
                    if (i_tx_mode_done) begin
                        words_nxt = words - 1'b1;
                        state_nxt = (words > P_CNT_W'(1)) ? DAT_PRE1 : CRC_PRE;
                    end
                end
                CRC_PRE:   if (i_tx_mode_done) state_nxt = CRC_TOK;
                CRC_TOK:   if (i_tx_mode_done) state_nxt = CRC_VAL;
                CRC_VAL:   if (i_tx_mode_done) state_nxt = END_PAT;
                END_PAT:   if (i_tx_mode_done) state_nxt = FINISH;
                FINISH:    state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end

        wdog_nxt = (in_field && (state_nxt == state)) ? wdog + 1'b1 : '0;

        field_nxt = (state_nxt != IDLE) && (state_nxt != FINISH);
        tx_en_nxt = field_nxt;
        busy_nxt  = field_nxt;
        done_nxt  = (state_nxt == FINISH);

        // Mode is registered from the next state so it changes with the state.
        case (state_nxt)
            CMD_RNW:  mode_nxt = rnw_nxt ? 4'b0010 : 4'b0110;
            CMD_ZEROS: mode_nxt = 4'b0011;
            CMD_ADDR: mode_nxt = 4'b0001;
            CMD_PAR:  mode_nxt = 4'b0100;
            DAT_PRE1: mode_nxt = 4'b0010;
            DAT_PRE0: mode_nxt = 4'b0110;
            DAT_B1:   mode_nxt = 4'b0111;
            DAT_B2:   mode_nxt = 4'b0111;
            DAT_PAR:  mode_nxt = 4'b0100;
            CRC_TOK:  mode_nxt = 4'b1100;
            CRC_VAL:  mode_nxt = 4'b1101;
            END_PAT:  mode_nxt = restart_nxt ? 4'b1111 : 4'b1110;
            default:  mode_nxt = 4'b0000;
        endcase
    end

endmodule
